// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//
// Contents:
//   uart_state_t        3-bit receiver state code
//   StIdle..StWaitIdle  receiver state encodings
//   CntWidth            width of the bit-timing down-counter (16 bits)
//   calc_sample_count() clk cycles per serial bit from clock and baud rate
//   calc_half_bit()     half-bit offset used to centre the start-bit sample
//
// The receiver's PARITY state exists only when UART_RX_PARITY_EN is defined.
// Its encoding is reserved here either way, so both builds and the transmitter
// agree on the state codes.

package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t StIdle     = 3'd0;
  localparam uart_state_t StStart    = 3'd1;
  localparam uart_state_t StData     = 3'd2;
  localparam uart_state_t StParity   = 3'd3;
  localparam uart_state_t StStop     = 3'd4;
  localparam uart_state_t StWaitIdle = 3'd5;

  // Bit-timing counter width; SAMPLE_COUNT above 65535 cannot be represented.
  localparam int unsigned CntWidth = 16;

  function automatic int unsigned calc_sample_count(input int unsigned clock_freq,
                                                    input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int unsigned calc_half_bit(input int unsigned sample_count);
    return sample_count / 2;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable bit-timing down-counter with a zero flag.
//
// Ports:
//   clk         clock, rising edge
//   reset_n     synchronous active-low reset (count returns to 0)
//   load_i      load load_val_i this cycle (takes priority over counting)
//   load_val_i  value to load, CntWidth bits
//   zero_o      high while the count is zero
//
// The counter decrements once per clk and holds at zero, so zero_o stays high
// until the next load. The receiver reloads on every sample point.

module uart_baud_cnt
  import uart_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_i,
  input  logic [CntWidth-1:0] load_val_i,
  output logic                zero_o
);

  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver with mid-bit sampling.
//
// Frame: start bit (0), 8 data bits LSB first, optional even-parity bit, one
// stop bit (1).
//
// Parameters:
//   BAUD_RATE     serial bit rate in bits/s
//   CLOCK_FREQ    clk frequency in Hz
//   SAMPLE_COUNT  clk cycles per bit (default CLOCK_FREQ/BAUD_RATE, max 65535)
//
// Ports:
//   clk         clock, rising edge
//   reset_n     synchronous active-low reset
//   rx          asynchronous serial input, idle high
//   data        last correctly received byte, held between frames
//   valid       one-cycle pulse: data holds a new byte
//   frame_err   one-cycle pulse: stop bit sampled low
//   parity_err  one-cycle pulse: parity mismatch (always 0 without parity)
//   busy        high whenever the receiver is not idle
//
// Build option:
//   UART_RX_PARITY_EN  when defined, a parity bit follows the data bits and is
//                      checked for even parity. A bad byte is reported at the
//                      stop-bit decision and is not written to data.

module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned CLOCK_FREQ   = 12_000_000,
  parameter int unsigned SAMPLE_COUNT = calc_sample_count(CLOCK_FREQ, BAUD_RATE)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  // Full bit for data/parity/stop; half bit so the start bit is sampled mid-bit.
  localparam logic [CntWidth-1:0] FullLoad = CntWidth'(SAMPLE_COUNT - 1);
  localparam logic [CntWidth-1:0] HalfLoad = CntWidth'(calc_half_bit(SAMPLE_COUNT) - 1);

  // Synchronizer and edge-detect history; all reset to the idle level so a
  // reset release on an idle line cannot look like a start edge.
  logic sync1_q, sync1_d;
  logic rx_s_q, rx_s_d;
  logic rx_prev_q, rx_prev_d;

  uart_state_t state_q, state_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;

  logic                cnt_load;
  logic [CntWidth-1:0] cnt_load_val;
  logic                cnt_zero;

`ifdef UART_RX_PARITY_EN
  // Result of the parity check, held from the PARITY sample to the stop-bit
  // decision so both error flags can be reported together.
  logic parity_bad_q, parity_bad_d;
  logic parity_err_q, parity_err_d;
`else
  logic parity_bad_q;
  assign parity_bad_q = 1'b0;
`endif

  uart_baud_cnt u_baud_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    sync1_d   = rx;
    rx_s_d    = sync1_q;
    rx_prev_d = rx_s_q;
  end

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = FullLoad;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s_q) begin
          cnt_load     = 1'b1;
          cnt_load_val = HalfLoad;
          state_d      = StStart;
        end
      end

      StStart: begin
        if (cnt_zero) begin
          if (!rx_s_q) begin
            cnt_load  = 1'b1;
            bit_idx_d = 3'd0;
            state_d   = StData;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = StIdle;
          end
        end
      end

      StData: begin
        if (cnt_zero) begin
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
          shift_d  = {rx_s_q, shift_q[7:1]};
          cnt_load = 1'b1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_zero) begin
          parity_bad_d = (rx_s_q != ^shift_q);
          cnt_load     = 1'b1;
          state_d      = StStop;
        end
      end
`endif

      StStop: begin
        if (cnt_zero) begin
`ifdef UART_RX_PARITY_EN
          parity_err_d = parity_bad_q;
`endif
          if (rx_s_q) begin
            if (!parity_bad_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
            state_d = StIdle;
          end else begin
            // A low stop bit may be a break; wait for the line to idle before
            // looking for the next start edge.
            frame_err_d = 1'b1;
            state_d     = StWaitIdle;
          end
        end
      end

      StWaitIdle: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= StIdle;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
// Runs with a short bit time (40 clk per bit) so every scenario stays small.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant.

module tb_uart_rx;

  localparam int SC  = 40;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = SC / 2 + 10 * SC + 3;
`else
  localparam int LAT = SC / 2 + 9 * SC + 3;
`endif

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int fall_cyc = 0;
  int v_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int both_cnt = 0;
  int v_cyc = 0;
  logic [7:0] rx_log [16];

  uart_rx #(
    .BAUD_RATE    (9600),
    .CLOCK_FREQ   (9600 * SC),
    .SAMPLE_COUNT (SC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (valid) begin
      if (v_cnt < 16) rx_log[v_cnt] = data;
      v_cnt = v_cnt + 1;
      v_cyc = cyc;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (parity_err) pe_cnt = pe_cnt + 1;
    if (valid && frame_err) both_cnt = both_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    rx = 1'b0;
    fall_cyc = cyc;
    wait_cycles(SC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(SC);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    wait_cycles(SC);
`else
    if (par) rx = 1'b1;  // no parity slot in this build
`endif
    rx = stop;
    wait_cycles(SC);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    rx = 1'b1;
    wait_cycles(4);
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    wait_cycles(5);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    int vb = v_cnt;
    int fb = fe_cnt;
    int lat;
    send_frame(8'h55, 1'b1, ^8'h55);
    wait_cycles(SC);
    lat = v_cyc - fall_cyc;
    total++; if (v_cnt - vb !== 1) begin bad++; $display("FAIL basic_valid_cnt: got %0d want 1", v_cnt - vb); end
    total++; if (rx_log[vb] !== 8'h55) begin bad++; $display("FAIL basic_pulse_data: got %h want 55", rx_log[vb]); end
    total++; if (data !== 8'h55) begin bad++; $display("FAIL basic_data_hold: got %h want 55", data); end
    total++; if (fe_cnt - fb !== 0) begin bad++; $display("FAIL basic_ferr: got %0d want 0", fe_cnt - fb); end
    total++; if (lat < LAT - 1 || lat > LAT + 1) begin bad++; $display("FAIL basic_latency: got %0d want %0d+-1", lat, LAT); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b want 0", busy); end
  endtask

  task automatic test_glitch;
    int vb = v_cnt;
    int fb = fe_cnt;
    int pb = pe_cnt;
    int seen = 0;
    int idle_at;
    rx = 1'b0;
    fall_cyc = cyc;
    wait_cycles(12);
    rx = 1'b1;
    for (int k = 0; k < 2 * SC; k++) begin
      if (busy) seen = 1;
      else if (seen != 0) break;
      wait_cycles(1);
    end
    idle_at = cyc - fall_cyc;
    total++; if (seen !== 1) begin bad++; $display("FAIL glitch_busy_seen: got %0d want 1", seen); end
    total++; if (idle_at > SC / 2 + 10) begin bad++; $display("FAIL glitch_idle_time: got %0d want <=%0d", idle_at, SC / 2 + 10); end
    wait_cycles(SC);
    total++; if (v_cnt - vb + fe_cnt - fb + pe_cnt - pb !== 0) begin
      bad++; $display("FAIL glitch_pulses: got %0d want 0", v_cnt - vb + fe_cnt - fb + pe_cnt - pb);
    end
  endtask

  task automatic test_frame_err;
    int vb = v_cnt;
    int fb = fe_cnt;
    send_frame(8'hA5, 1'b0, ^8'hA5);
    wait_cycles(2 * SC);  // line stays low after the bad stop bit
    total++; if (fe_cnt - fb !== 1) begin bad++; $display("FAIL ferr_pulse: got %0d want 1", fe_cnt - fb); end
    total++; if (v_cnt - vb !== 0) begin bad++; $display("FAIL ferr_no_valid: got %0d want 0", v_cnt - vb); end
    total++; if (data !== 8'h55) begin bad++; $display("FAIL ferr_data_kept: got %h want 55", data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_wait_busy: got %b want 1", busy); end
    rx = 1'b1;
    wait_cycles(SC);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_idle_busy: got %b want 0", busy); end
    send_frame(8'h3C, 1'b1, ^8'h3C);
    wait_cycles(SC);
    total++; if (v_cnt - vb !== 1) begin bad++; $display("FAIL ferr_next_valid: got %0d want 1", v_cnt - vb); end
    total++; if (data !== 8'h3C) begin bad++; $display("FAIL ferr_next_data: got %h want 3c", data); end
  endtask

  task automatic test_back_to_back;
    int vb = v_cnt;
    int fb = fe_cnt;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    wait_cycles(SC);
    total++; if (v_cnt - vb !== 2) begin bad++; $display("FAIL b2b_valid_cnt: got %0d want 2", v_cnt - vb); end
    total++; if (rx_log[vb] !== 8'hA5) begin bad++; $display("FAIL b2b_first: got %h want a5", rx_log[vb]); end
    total++; if (rx_log[vb+1] !== 8'h3C) begin bad++; $display("FAIL b2b_second: got %h want 3c", rx_log[vb+1]); end
    total++; if (fe_cnt - fb !== 0) begin bad++; $display("FAIL b2b_ferr: got %0d want 0", fe_cnt - fb); end
  endtask

  task automatic test_mid_reset;
    int vb = v_cnt;
    int fb = fe_cnt;
    rx = 1'b0;
    wait_cycles(SC);
    rx = 1'b1;  // 0xFF: every data bit high
    wait_cycles(4 * SC + SC / 2);
    reset_n = 1'b0;
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(SC / 2 - 3 + 3 * SC + SC + SC);
    total++; if (v_cnt - vb !== 0) begin bad++; $display("FAIL mrst_no_valid: got %0d want 0", v_cnt - vb); end
    total++; if (fe_cnt - fb !== 0) begin bad++; $display("FAIL mrst_no_ferr: got %0d want 0", fe_cnt - fb); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL mrst_data: got %h want 00", data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_busy: got %b want 0", busy); end
    send_frame(8'h81, 1'b1, ^8'h81);
    wait_cycles(SC);
    total++; if (v_cnt - vb !== 1) begin bad++; $display("FAIL mrst_next_valid: got %0d want 1", v_cnt - vb); end
    total++; if (data !== 8'h81) begin bad++; $display("FAIL mrst_next_data: got %h want 81", data); end
  endtask

  task automatic test_parity;
`ifdef UART_RX_PARITY_EN
    int vb = v_cnt;
    int fb = fe_cnt;
    int pb = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);  // even parity of 0x07 is 1
    wait_cycles(SC);
    total++; if (pe_cnt - pb !== 1) begin bad++; $display("FAIL par_pulse: got %0d want 1", pe_cnt - pb); end
    total++; if (v_cnt - vb !== 0) begin bad++; $display("FAIL par_no_valid: got %0d want 0", v_cnt - vb); end
    total++; if (data !== 8'h81) begin bad++; $display("FAIL par_data_kept: got %h want 81", data); end
    total++; if (fe_cnt - fb !== 0) begin bad++; $display("FAIL par_no_ferr: got %0d want 0", fe_cnt - fb); end
    send_frame(8'h07, 1'b0, 1'b0);
    rx = 1'b1;
    wait_cycles(SC);
    total++; if (pe_cnt - pb !== 2) begin bad++; $display("FAIL par_both_perr: got %0d want 2", pe_cnt - pb); end
    total++; if (fe_cnt - fb !== 1) begin bad++; $display("FAIL par_both_ferr: got %0d want 1", fe_cnt - fb); end
    send_frame(8'h07, 1'b1, 1'b1);
    wait_cycles(SC);
    total++; if (data !== 8'h07) begin bad++; $display("FAIL par_good_data: got %h want 07", data); end
`else
    total++; if (pe_cnt !== 0) begin bad++; $display("FAIL nopar_perr_cnt: got %0d want 0", pe_cnt); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL nopar_perr: got %b want 0", parity_err); end
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    rx = 1'b1;
    wait_cycles(1);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_mid_reset();
    test_parity();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL valid_ferr_overlap: got %0d want 0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
